// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the mem_responder word memory.
interface mem_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;
  logic        Busy;

  modport master (
    output MemReq, MemWrite, Adr, WriteData,
    input  ReadData, MemReady, MemErr, Busy
  );

  modport slave (
    input  MemReq, MemWrite, Adr, WriteData,
    output ReadData, MemReady, MemErr, Busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory target with programmable wait states, one-cycle ready
// pulse and an error response for misaligned or out-of-range addresses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for MemReq; request fields captured on acceptance
// ST_WAIT | wait-state countdown, bus inputs ignored
// ST_RESP | MemReady/MemErr/ReadData presented for exactly one cycle
module mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] adr_q, wdata_q;
  logic        write_q;
  logic        capture, enter_resp;

  logic [31:0] eff_adr, eff_wdata;
  logic        eff_write;
  logic        err;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic        ready_q, err_q;

  // With WAIT=0 the response is committed on the accepting edge, so the live
  // bus fields stand in for the not-yet-captured registers.
  assign eff_adr   = (state == ST_IDLE) ? bus.Adr       : adr_q;
  assign eff_wdata = (state == ST_IDLE) ? bus.WriteData : wdata_q;
  assign eff_write = (state == ST_IDLE) ? bus.MemWrite  : write_q;

  assign err = (eff_adr[1:0] != 2'b00) || (eff_adr >= 32'(4 * DEPTH));
  assign idx = eff_adr[AW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.MemReq) begin
          capture = 1'b1;
          if (WAIT == 0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_nxt   = 4'(WAIT);
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      adr_q   <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      ready_q <= enter_resp;
      err_q   <= enter_resp && err;
      if (capture) begin
        adr_q   <= bus.Adr;
        wdata_q <= bus.WriteData;
        write_q <= bus.MemWrite;
      end
      if (enter_resp) begin
        if (err) begin
          rdata_q <= 32'd0;
        end else if (!eff_write) begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (enter_resp && eff_write && !err) begin
      mem[idx] <= eff_wdata;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.MemReady = ready_q;
  assign bus.MemErr   = err_q;
  assign bus.Busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: WAIT=2 and WAIT=0 instances, vector
// table plus hand sequences for back-to-back, mid-transaction and reset cases.
module tb_mem_responder;
  logic clk;
  logic reset;
  logic req2, req0;
  logic wr_d;
  logic [31:0] adr_d, wd_d;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t sb2[$];
  exp_t sb0[$];
  vec_t vecs[15];

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  assign bus2.MemReq    = req2;
  assign bus2.MemWrite  = wr_d;
  assign bus2.Adr       = adr_d;
  assign bus2.WriteData = wd_d;
  assign bus0.MemReq    = req0;
  assign bus0.MemWrite  = wr_d;
  assign bus0.Adr       = adr_d;
  assign bus0.WriteData = wd_d;

  mem_responder #(.DEPTH(64), .WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mem_responder #(.DEPTH(64), .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon2
    exp_t e;
    if (bus2.MemReady === 1'b1) begin
      if (sb2.size() == 0) begin
        check("unexpected_ready2", 32'd1, 32'd0);
      end else begin
        e = sb2.pop_front();
        check("rdata2", bus2.ReadData, e.rdata);
        check("err2", {31'd0, bus2.MemErr}, {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.MemReady === 1'b1) begin
      if (sb0.size() == 0) begin
        check("unexpected_ready0", 32'd1, 32'd0);
      end else begin
        e = sb0.pop_front();
        check("rdata0", bus0.ReadData, e.rdata);
        check("err0", {31'd0, bus0.MemErr}, {31'd0, e.err});
      end
    end
  end

  // sel=1 targets the WAIT=0 instance; corrupt scrambles the bus after acceptance
  task automatic txn(input bit sel, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input bit corrupt);
    int   lat;
    int   waitv;
    exp_t e;
    waitv = sel ? 0 : 2;
    @(negedge clk);
    wr_d  = wr;
    adr_d = a;
    wd_d  = d;
    e.rdata = exp_rd;
    e.err   = exp_err;
    if (sel) begin
      req0 = 1'b1;
      sb0.push_back(e);
    end else begin
      req2 = 1'b1;
      sb2.push_back(e);
    end
    @(posedge clk); #1;
    check("busy", {31'd0, sel ? bus0.Busy : bus2.Busy}, 32'd1);
    if (corrupt) begin
      adr_d = a ^ 32'h4;
      wd_d  = ~d;
      wr_d  = ~wr;
    end
    lat = 0;
    while (lat < 20 && (sel ? bus0.MemReady : bus2.MemReady) !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, waitv);
    @(negedge clk);
    req0 = 1'b0;
    req2 = 1'b0;
    @(posedge clk); #1;
    check("ready_pulse", {31'd0, sel ? bus0.MemReady : bus2.MemReady}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   cyc;
    int   nr;
    int   rt[3];
    exp_t e;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h12,       32'h12345678, 32'h00000000, 1'b1};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h100,      32'h0,        32'h00000000, 1'b1};
    vecs[5]  = '{1'b1, 32'hFC,       32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b0, 32'hFC,       32'h0,        32'hCAFEF00D, 1'b0};
    vecs[7]  = '{1'b0, 32'h101,      32'h0,        32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 32'h08,       32'h88888888, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b1, 32'h0C,       32'hCCCCCCCC, 32'h00000000, 1'b0};
    vecs[10] = '{1'b0, 32'h08,       32'h0,        32'h88888888, 1'b0};
    vecs[11] = '{1'b1, 32'h20,       32'h0BADF00D, 32'h88888888, 1'b0};
    vecs[12] = '{1'b0, 32'h20,       32'h0,        32'h0BADF00D, 1'b0};
    vecs[13] = '{1'b0, 32'hFFFFFFFC, 32'h0,        32'h00000000, 1'b1};
    vecs[14] = '{1'b0, 32'h0C,       32'h0,        32'hCCCCCCCC, 1'b0};

    reset = 1'b0;
    req2  = 1'b0;
    req0  = 1'b0;
    wr_d  = 1'b0;
    adr_d = 32'd0;
    wd_d  = 32'd0;
    #3;
    check("rst_rdata", bus2.ReadData, 32'd0);
    check("rst_ready", {31'd0, bus2.MemReady}, 32'd0);
    check("rst_err",   {31'd0, bus2.MemErr},   32'd0);
    check("rst_busy",  {31'd0, bus2.Busy},     32'd0);
    check("rst_busy0", {31'd0, bus0.Busy},     32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      txn(1'b0, vecs[i].wr, vecs[i].adr, vecs[i].wd, vecs[i].rd, vecs[i].err, 1'b0);
    end

    // zero-wait instance
    txn(1'b1, 1'b1, 32'h00, 32'h00000005, 32'h00000000, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 32'h00, 32'h0,        32'h00000005, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 32'h02, 32'h0,        32'h00000000, 1'b1, 1'b0);

    // bus changes during the wait states must not leak into the response
    txn(1'b0, 1'b0, 32'h08, 32'h0, 32'h88888888, 1'b0, 1'b1);
    txn(1'b0, 1'b0, 32'h0C, 32'h0, 32'hCCCCCCCC, 1'b0, 1'b0);

    // MemReq held high: three reads spaced WAIT+2 cycles apart
    @(negedge clk);
    wr_d  = 1'b0;
    adr_d = 32'h10;
    req2  = 1'b1;
    e.rdata = 32'hDEADBEEF;
    e.err   = 1'b0;
    for (int i = 0; i < 3; i++) sb2.push_back(e);
    cyc = 0;
    nr  = 0;
    rt  = '{0, 0, 0};
    while (cyc < 40 && nr < 3) begin
      @(posedge clk); #1;
      cyc++;
      if (bus2.MemReady === 1'b1) begin
        rt[nr] = cyc;
        nr++;
      end
    end
    @(negedge clk);
    req2 = 1'b0;
    check("b2b_first",  rt[0], 3);
    check("b2b_space1", rt[1] - rt[0], 4);
    check("b2b_space2", rt[2] - rt[1], 4);

    // reset one cycle after accepting a write aborts it
    @(negedge clk);
    wr_d  = 1'b1;
    adr_d = 32'h20;
    wd_d  = 32'hAAAA5555;
    req2  = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    req2 = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("abort_busy",  {31'd0, bus2.Busy},     32'd0);
    check("abort_ready", {31'd0, bus2.MemReady}, 32'd0);
    check("abort_err",   {31'd0, bus2.MemErr},   32'd0);
    check("abort_rdata", bus2.ReadData,          32'd0);
    @(negedge clk);
    reset = 1'b1;
    txn(1'b0, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);

    // reset during RESP drops MemReady at once; the committed write persists
    @(negedge clk);
    wr_d  = 1'b1;
    adr_d = 32'h30;
    wd_d  = 32'h30303030;
    req2  = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 20 && bus2.MemReady !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    check("resp_lat", lat, 2);
    reset = 1'b0;
    req2  = 1'b0;
    #1;
    check("resp_rst_ready", {31'd0, bus2.MemReady}, 32'd0);
    check("resp_rst_busy",  {31'd0, bus2.Busy},     32'd0);
    @(negedge clk);
    reset = 1'b1;
    txn(1'b0, 1'b0, 32'h30, 32'h0, 32'h30303030, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb2_drained", sb2.size(), 0);
    check("sb0_drained", sb0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
